// File: rtl/bridge_pkg.sv
// Shared types for the 4-phase bridge.
// tx_state_t : transmitter handshake state.
// Latency/backpressure: n/a (types only).
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_ON  = 2'd1,
    REQ_OFF = 2'd2
  } tx_state_t;

endpackage

// File: rtl/defines.sv
// Project-wide defines.
// WIDTH : default data word width for the transmit path.
`ifndef WIDTH
`define WIDTH 8
`endif

// File: rtl/tx_fifo.sv
// Purpose: small synchronous FIFO holding words waiting for the link.
// Latency: a pushed word is visible on rd_data (head, unregistered) after one edge.
// Backpressure: push while full is dropped; pop while empty is ignored.
// Ports: clk, rst (sync, active-low flush), wr_en/wr_data (push),
//        rd_en/rd_data (pop / head word), full, empty.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // Full is evaluated before any same-cycle pop, so a push while full is
  // dropped even when the head leaves in the same cycle.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/transmitter.sv
// Purpose: drains the local FIFO onto a 4-phase req/ack link, one word per handshake.
// Latency: word pushed into an empty FIFO at edge k raises req after edge k+1; 5 cycles/word min.
// Backpressure: waits indefinitely on ack; FIFO full drops further pushes.
// Ports: clk, rst (sync, active-low), en (allow launch), wr_en/wr_data (push),
//        full/empty (FIFO status), req/ack (link handshake), data_out (link word),
//        busy (handshake in progress), done (1-cycle per transfer), tx_cnt (transfers).
`ifndef WIDTH
`define WIDTH 8
`endif

module transmitter
  import bridge_pkg::*;
#(
  parameter int WIDTH = `WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic             req,
  input  logic             ack,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic [15:0]      tx_cnt
);

  tx_state_t        state;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data;

  // Pop only on the launching edge; the head word is captured into data_out
  // on that same edge so the link word is stable for the whole handshake.
  assign fifo_rd_en = (state == IDLE) && en && !empty;

  tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (full),
    .empty   (empty)
  );

  // req and busy are registered alongside state, so ack never reaches req
  // combinationally. en is only consulted in IDLE: dropping it mid-transfer
  // lets the current handshake finish.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      req      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      tx_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_rd_en) begin
            state    <= REQ_ON;
            req      <= 1'b1;
            busy     <= 1'b1;
            data_out <= fifo_rd_data;
          end
        end
        REQ_ON: begin
          if (ack) begin
            state <= REQ_OFF;
            req   <= 1'b0;
          end
        end
        REQ_OFF: begin
          if (!ack) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            tx_cnt <= tx_cnt + 16'd1;  // wraps 0xFFFF -> 0x0000
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter paired with a behavioural 4-phase receiver.
// Stimulus pushes expected link words into a queue; a negedge monitor pops
// and compares each time the receiver accepts a word (req & rising ack).
module tb_transmitter;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         full;
  logic         empty;
  logic         req;
  logic         ack;
  logic [W-1:0] data_out;
  logic         busy;
  logic         done;
  logic [15:0]  tx_cnt;

  logic         rx_en;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           rx_count = 0;
  int           done_count = 0;
  logic [W-1:0] exp_q[$];
  int           rise_q[$];
  logic         prev_ack = 1'b0;
  logic         prev_req = 1'b0;

  transmitter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .req      (req),
    .ack      (ack),
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .tx_cnt   (tx_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: raises ack one cycle after req (when enabled), drops it one
  // cycle after req falls.
  always @(posedge clk) begin
    if (!rst) ack <= 1'b0;
    else      ack <= req && (rx_en || ack);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (req && !prev_req) rise_q.push_back(cyc);
    if (req && ack && !prev_ack) begin
      rx_count++;
      if (exp_q.size() == 0) begin
        chk("rx_unexpected_word", {24'd0, data_out}, 32'hFFFF_FFFF);
      end else begin
        chk("rx_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
    end
    if (done) done_count++;
    prev_ack = ack;
    prev_req = req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input bit expect_rx);
    wr_en   = 1'b1;
    wr_data = d;
    if (expect_rx) exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 300 && done_count < n; i++) tick();
    chk("done_wait_timeout", done_count >= n, 1);
  endtask

  logic [W-1:0] held;
  int           rx_before;

  initial begin
    rst     = 1'b0;
    en      = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rx_en   = 1'b1;
    repeat (3) tick();

    // Reset state.
    chk("rst_req",      req,      0);
    chk("rst_empty",    empty,    1);
    chk("rst_full",     full,     0);
    chk("rst_busy",     busy,     0);
    chk("rst_done",     done,     0);
    chk("rst_tx_cnt",   tx_cnt,   0);
    chk("rst_data_out", data_out, 0);
    rst = 1'b1;
    tick();

    // Single word: req rises after edge k+1.
    push(8'hA5, 1);
    chk("lat_req_k",    req,   0);
    chk("lat_empty_k",  empty, 0);
    tick();
    chk("lat_req_k1",   req,      1);
    chk("lat_data_k1",  data_out, 8'hA5);
    chk("lat_busy_k1",  busy,     1);
    wait_done(1);
    repeat (3) tick();
    chk("one_tx_cnt",   tx_cnt,     1);
    chk("one_done_cnt", done_count, 1);
    chk("one_empty",    empty,      1);
    chk("idle_hold_data", data_out, 8'hA5);

    // Three back-to-back words, one launch every 5 cycles.
    rise_q.delete();
    push(8'h01, 1);
    push(8'h02, 1);
    push(8'h03, 1);
    wait_done(4);
    repeat (3) tick();
    chk("b2b_rises", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      chk("b2b_gap0", rise_q[1] - rise_q[0], 5);
      chk("b2b_gap1", rise_q[2] - rise_q[1], 5);
    end
    chk("b2b_tx_cnt", tx_cnt, 4);
    chk("b2b_empty",  empty,  1);

    // Receiver stalled: req, busy and data_out hold, no done.
    rx_en = 1'b0;
    push(8'h5A, 1);
    tick();
    chk("stall_req", req, 1);
    held = data_out;
    chk("stall_data", data_out, 8'h5A);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_hold", {21'd0, req, busy, done, data_out}, {21'd0, 1'b1, 1'b1, 1'b0, held});
    end
    rx_en = 1'b1;
    wait_done(5);
    repeat (3) tick();

    // Overflow: six pushes, first popped, four queued, sixth dropped.
    rx_en = 1'b0;
    push(8'h11, 1);
    push(8'h12, 1);
    push(8'h13, 1);
    push(8'h14, 1);
    push(8'h15, 1);
    push(8'h16, 0);
    chk("ovf_full",  full,     1);
    chk("ovf_empty", empty,    0);
    chk("ovf_data",  data_out, 8'h11);
    chk("ovf_req",   req,      1);
    rx_before = rx_count;
    rx_en = 1'b1;
    wait_done(10);
    repeat (10) tick();
    chk("ovf_rx_words", rx_count - rx_before, 5);
    chk("ovf_tx_cnt",   tx_cnt, 10);
    chk("ovf_empty_end", empty, 1);

    // Reset mid-transfer with two words queued; pushes during reset discarded.
    rx_en = 1'b0;
    push(8'h21, 0);
    push(8'h22, 0);
    push(8'h23, 0);
    chk("mid_req", req, 1);
    chk("mid_empty", empty, 0);
    rst     = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h77;
    tick();
    chk("mrst_req",      req,      0);
    chk("mrst_empty",    empty,    1);
    chk("mrst_full",     full,     0);
    chk("mrst_tx_cnt",   tx_cnt,   0);
    chk("mrst_data_out", data_out, 0);
    chk("mrst_busy",     busy,     0);
    rst   = 1'b1;
    wr_en = 1'b0;
    tick();
    chk("rst_push_discard", empty, 1);
    chk("rst_push_noreq",   req,   0);
    rx_en = 1'b1;
    tick();

    // Counter wrap.
    force dut.tx_cnt = 16'hFFFF;
    tick();
    release dut.tx_cnt;
    tick();
    chk("wrap_preload", tx_cnt, 16'hFFFF);
    push(8'h3C, 1);
    wait_done(11);
    repeat (3) tick();
    chk("wrap_tx_cnt",   tx_cnt,     0);
    chk("wrap_done_cnt", done_count, 11);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
